// File: rtl/clock_time_controller_if.sv
// Request/response bundle for the 12-hour alarm clock controller.
// The bench drives requests through master; the controller sits on slave.
interface clock_time_controller_if;
   logic       tick_1hz;
   logic       sec_adj;
   logic       min_adj;
   logic       hrs_adj;
   logic       al_adj;
   logic       al_toggle;
   logic       buzz_clk;
   logic [5:0] seconds;
   logic [5:0] minutes;
   logic [3:0] hours;
   logic [5:0] al_minutes;
   logic [3:0] al_hours;
   logic       al_on;
   logic       alarm;
   logic       buzzer_out;
   logic       busy;

   modport master (
      output tick_1hz, sec_adj, min_adj, hrs_adj, al_adj, al_toggle, buzz_clk,
      input  seconds, minutes, hours, al_minutes, al_hours,
      input  al_on, alarm, buzzer_out, busy
   );

   modport slave (
      input  tick_1hz, sec_adj, min_adj, hrs_adj, al_adj, al_toggle, buzz_clk,
      output seconds, minutes, hours, al_minutes, al_hours,
      output al_on, alarm, buzzer_out, busy
   );
endinterface

// File: rtl/clock_time_controller.sv
// 12-hour clock with alarm, one pending request serviced per cycle.
// Optional CLOCK_AUTO_SILENCE_EN stops the alarm after 60 serviced ticks.
module clock_time_controller (
   input  logic                  clk,
   input  logic                  reset,
   clock_time_controller_if.slave bus
);
   logic [5:0] pend_q, pend_d, req, grant;
   logic [5:0] seconds_q, seconds_d;
   logic [5:0] minutes_q, minutes_d;
   logic [3:0] hours_q, hours_d;
   logic [5:0] al_minutes_q, al_minutes_d;
   logic [3:0] al_hours_q, al_hours_d;
   logic       al_on_q, al_on_d;
   logic       alarm_q, alarm_d;
   logic       phase_q, phase_d;
`ifdef CLOCK_AUTO_SILENCE_EN
   logic [5:0] silence_q, silence_d;
`endif

   assign req = {bus.al_toggle, bus.al_adj, bus.hrs_adj,
                 bus.min_adj, bus.sec_adj, bus.tick_1hz};
   // lowest set bit wins: bit 0 (tick) has top priority
   assign grant = pend_q & (~pend_q + 6'd1);

   always_comb begin
      pend_d       = (pend_q & ~grant) | req;
      seconds_d    = seconds_q;
      minutes_d    = minutes_q;
      hours_d      = hours_q;
      al_minutes_d = al_minutes_q;
      al_hours_d   = al_hours_q;
      al_on_d      = al_on_q;
      alarm_d      = alarm_q;
      phase_d      = alarm_q & (phase_q ^ bus.buzz_clk);
`ifdef CLOCK_AUTO_SILENCE_EN
      silence_d    = silence_q;
`endif
      unique case (1'b1)
         grant[0]: begin
            seconds_d = (seconds_q == 6'd59) ? 6'd0 : seconds_q + 6'd1;
            if (seconds_q == 6'd59) begin
               minutes_d = (minutes_q == 6'd59) ? 6'd0 : minutes_q + 6'd1;
               if (minutes_q == 6'd59)
                  hours_d = (hours_q == 4'd11) ? 4'd0 : hours_q + 4'd1;
            end
            if (al_on_q && seconds_d == 6'd0 &&
                minutes_d == al_minutes_q && hours_d == al_hours_q) begin
               alarm_d = 1'b1;
`ifdef CLOCK_AUTO_SILENCE_EN
               silence_d = 6'd0;
            end else if (alarm_q) begin
               if (silence_q == 6'd59)
                  alarm_d = 1'b0;
               silence_d = silence_q + 6'd1;
`endif
            end
         end
         grant[1]:
            seconds_d = (seconds_q == 6'd59) ? 6'd0 : seconds_q + 6'd1;
         grant[2]:
            minutes_d = (minutes_q == 6'd59) ? 6'd0 : minutes_q + 6'd1;
         grant[3]:
            hours_d = (hours_q == 4'd11) ? 4'd0 : hours_q + 4'd1;
         grant[4]: begin
            if (al_minutes_q == 6'd50) begin
               al_minutes_d = 6'd0;
               al_hours_d   = (al_hours_q == 4'd11) ? 4'd0 : al_hours_q + 4'd1;
            end else begin
               al_minutes_d = al_minutes_q + 6'd10;
            end
         end
         grant[5]: begin
            if (al_on_q) begin
               al_on_d = 1'b0;
               alarm_d = 1'b0;
            end else begin
               al_on_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pend_q       <= 6'd0;
         seconds_q    <= 6'd0;
         minutes_q    <= 6'd0;
         hours_q      <= 4'd0;
         al_minutes_q <= 6'd0;
         al_hours_q   <= 4'd0;
         al_on_q      <= 1'b1;
         alarm_q      <= 1'b0;
         phase_q      <= 1'b0;
`ifdef CLOCK_AUTO_SILENCE_EN
         silence_q    <= 6'd0;
`endif
      end else begin
         pend_q       <= pend_d;
         seconds_q    <= seconds_d;
         minutes_q    <= minutes_d;
         hours_q      <= hours_d;
         al_minutes_q <= al_minutes_d;
         al_hours_q   <= al_hours_d;
         al_on_q      <= al_on_d;
         alarm_q      <= alarm_d;
         phase_q      <= phase_d;
`ifdef CLOCK_AUTO_SILENCE_EN
         silence_q    <= silence_d;
`endif
      end
   end

   assign bus.seconds    = seconds_q;
   assign bus.minutes    = minutes_q;
   assign bus.hours      = hours_q;
   assign bus.al_minutes = al_minutes_q;
   assign bus.al_hours   = al_hours_q;
   assign bus.al_on      = al_on_q;
   assign bus.alarm      = alarm_q;
   assign bus.buzzer_out = alarm_q & phase_q;
   assign bus.busy       = |pend_q;
endmodule

// File: tb/tb_clock_time_controller.sv
// Bench for clock_time_controller: time-in-seconds reference model,
// per-cycle output compare, directed scenarios and random traffic.
`timescale 1ns/1ps
module tb_clock_time_controller;
   logic clk;
   logic reset;
   clock_time_controller_if bus ();

   clock_time_controller dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #16 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // reference: time as seconds since 00:00:00, alarm as 10-minute slot
   int       m_t;
   int       m_aidx;
   bit       m_on;
   bit       m_alarm;
   bit       m_phase;
   bit [5:0] m_pend;
   bit [5:0] m_req;
   int       m_scnt;
   int       m_g;
   int       m_f;
   bit       chk_en = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         m_t = 0; m_aidx = 0; m_on = 1; m_alarm = 0;
         m_phase = 0; m_pend = 0; m_scnt = 0;
         chk_en = 1'b1;
      end else begin
         m_req = {bus.al_toggle, bus.al_adj, bus.hrs_adj,
                  bus.min_adj, bus.sec_adj, bus.tick_1hz};
         m_g = -1;
         for (int i = 5; i >= 0; i--)
            if (m_pend[i]) m_g = i;
         m_phase = m_alarm & (m_phase ^ bus.buzz_clk);
         case (m_g)
            0: begin
               m_t = (m_t + 1) % 43200;
               if (m_on && (m_t % 60) == 0 && (m_t / 60) == m_aidx * 10) begin
                  m_alarm = 1; m_scnt = 0;
               end
`ifdef CLOCK_AUTO_SILENCE_EN
               else if (m_alarm) begin
                  m_scnt++;
                  if (m_scnt == 60) m_alarm = 0;
               end
`endif
            end
            1: begin
               m_f = m_t % 60;
               m_t = m_t - m_f + (m_f + 1) % 60;
            end
            2: begin
               m_f = (m_t / 60) % 60;
               m_t = m_t - m_f * 60 + ((m_f + 1) % 60) * 60;
            end
            3: begin
               m_f = m_t / 3600;
               m_t = m_t - m_f * 3600 + ((m_f + 1) % 12) * 3600;
            end
            4: m_aidx = (m_aidx + 1) % 72;
            5: begin
               if (m_on) begin m_on = 0; m_alarm = 0; end
               else m_on = 1;
            end
            default: ;
         endcase
         if (m_g >= 0) m_pend[m_g] = 1'b0;
         m_pend = m_pend | m_req;
      end
   end

   logic [35:0] act_v, exp_v;
   always @(negedge clk) begin
      if (chk_en) begin
         exp_v = {6'(m_t % 60), 6'((m_t / 60) % 60), 4'(m_t / 3600),
                  6'((m_aidx % 6) * 10), 4'(m_aidx / 6),
                  m_on, m_alarm, m_alarm & m_phase, |m_pend};
         act_v = {bus.seconds, bus.minutes, bus.hours,
                  bus.al_minutes, bus.al_hours,
                  bus.al_on, bus.alarm, bus.buzzer_out, bus.busy};
         n_cmp++;
         if (act_v !== exp_v) begin
            n_bad++;
            $display("FAIL model_cmp t=%0t: dut=%h model=%h", $time, act_v, exp_v);
         end
      end
   end

   task automatic lit(input string nm, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      bus.tick_1hz = 0; bus.sec_adj = 0; bus.min_adj = 0;
      bus.hrs_adj = 0; bus.al_adj = 0; bus.al_toggle = 0;
      bus.buzz_clk = 0;
   endtask

   task automatic set_req(input int which);
      case (which)
         0: bus.tick_1hz  = 1;
         1: bus.sec_adj   = 1;
         2: bus.min_adj   = 1;
         3: bus.hrs_adj   = 1;
         4: bus.al_adj    = 1;
         default: bus.al_toggle = 1;
      endcase
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (bus.busy && k < 20) begin
         step();
         k++;
      end
      n_cmp++;
      if (bus.busy) begin
         n_bad++;
         $display("FAIL drain_timeout: busy=%0d required 0", bus.busy);
      end
   endtask

   task automatic adj(input int which, input int n);
      for (int i = 0; i < n; i++) begin
         set_req(which);
         step();
      end
      drain();
   endtask

   task automatic do_reset();
      reset = 1;
      step();
      reset = 0;
   endtask

   initial begin
      reset = 1;
      bus.tick_1hz = 0; bus.sec_adj = 0; bus.min_adj = 0;
      bus.hrs_adj = 0; bus.al_adj = 0; bus.al_toggle = 0;
      bus.buzz_clk = 0;
      step();
      step();
      reset = 0;
      lit("rst_seconds", bus.seconds, 0);
      lit("rst_al_on", bus.al_on, 1);
      lit("rst_busy", bus.busy, 0);

      // three contending requests: serviced on successive edges
      set_req(0); set_req(2); set_req(4);
      step();
      lit("cont_busy1", bus.busy, 1);
      lit("cont_sec_n", bus.seconds, 0);
      step();
      lit("cont_sec_n1", bus.seconds, 1);
      lit("cont_min_n1", bus.minutes, 0);
      lit("cont_busy2", bus.busy, 1);
      step();
      lit("cont_min_n2", bus.minutes, 1);
      lit("cont_alm_n2", bus.al_minutes, 0);
      lit("cont_busy3", bus.busy, 1);
      step();
      lit("cont_alm_n3", bus.al_minutes, 10);
      lit("cont_busy4", bus.busy, 0);

      // 00:59:59 + tick -> 01:00:00
      do_reset();
      adj(2, 59);
      adj(1, 59);
      set_req(0);
      step();
      lit("carry_sec_n", bus.seconds, 59);
      step();
      lit("carry_hrs", bus.hours, 1);
      lit("carry_min", bus.minutes, 0);
      lit("carry_sec", bus.seconds, 0);
      lit("carry_busy", bus.busy, 0);

      // min_adj wrap without carry; merged sec_adj
      do_reset();
      adj(3, 3);
      adj(2, 59);
      adj(2, 1);
      lit("minwrap_min", bus.minutes, 0);
      lit("minwrap_hrs", bus.hours, 3);
      set_req(0); set_req(1);
      step();
      set_req(1);
      step();
      drain();
      lit("merge_sec", bus.seconds, 2);

      // 11:59:59 rollover hits alarm 00:00
      do_reset();
      adj(3, 11); adj(2, 59); adj(1, 59);
      adj(0, 1);
      lit("roll_hrs", bus.hours, 0);
      lit("roll_alarm", bus.alarm, 1);
      bus.buzz_clk = 1;
      step();
      lit("buzz_on", bus.buzzer_out, 1);
      bus.buzz_clk = 1;
      step();
      lit("buzz_off", bus.buzzer_out, 0);
      bus.buzz_clk = 1;
      step();
      adj(5, 1);
      lit("tog_alarm", bus.alarm, 0);
      lit("tog_al_on", bus.al_on, 0);
      lit("tog_buzz", bus.buzzer_out, 0);
      adj(3, 11); adj(2, 59); adj(1, 59);
      adj(0, 1);
      lit("disarmed_alarm", bus.alarm, 0);

      // alarm at 01:00 via six al_adj steps
      do_reset();
      adj(4, 6);
      lit("al6_hours", bus.al_hours, 1);
      lit("al6_min", bus.al_minutes, 0);
      adj(2, 59); adj(1, 59);
      adj(0, 1);
      lit("al1_alarm", bus.alarm, 1);
      for (int i = 0; i < 59; i++) adj(0, 1);
      lit("sil59_alarm", bus.alarm, 1);
      adj(0, 1);
`ifdef CLOCK_AUTO_SILENCE_EN
      lit("sil60_alarm", bus.alarm, 0);
      lit("sil60_al_on", bus.al_on, 1);
`else
      lit("nosil_alarm", bus.alarm, 1);
`endif

      // reset mid-alarm with requests pending
      do_reset();
      adj(3, 11); adj(2, 59); adj(1, 59);
      adj(0, 1);
      bus.buzz_clk = 1;
      step();
      set_req(0); set_req(1); set_req(4);
      step();
      reset = 1;
      set_req(2); set_req(5);
      step();
      reset = 0;
      lit("mr_alarm", bus.alarm, 0);
      lit("mr_buzz", bus.buzzer_out, 0);
      lit("mr_busy", bus.busy, 0);
      lit("mr_al_on", bus.al_on, 1);
      lit("mr_time", {bus.hours, bus.minutes, bus.seconds}, 0);
      lit("mr_al", {bus.al_hours, bus.al_minutes}, 0);

      // random traffic near the 00:00 alarm
      adj(3, 11); adj(2, 59);
      for (int c = 0; c < 3000; c++) begin
         bus.tick_1hz  = ($urandom_range(0, 2) == 0);
         bus.sec_adj   = ($urandom_range(0, 7) == 0);
         bus.min_adj   = ($urandom_range(0, 7) == 0);
         bus.hrs_adj   = ($urandom_range(0, 9) == 0);
         bus.al_adj    = ($urandom_range(0, 9) == 0);
         bus.al_toggle = ($urandom_range(0, 29) == 0);
         bus.buzz_clk  = ($urandom_range(0, 2) == 0);
         reset         = ($urandom_range(0, 499) == 0);
         step();
         reset = 0;
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
